// File: rtl/delay_pipe_pkg.sv
// Shared definitions for the delay_pipe block and for Latch users that need
// occupancy-sized typedefs.
package delay_pipe_pkg;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay_pipe_stage.sv
// One register stage of delay_pipe: a data register plus its valid bit.
// Advances on i_en, clears only the valid bit on i_flush, and clears both
// registers on the synchronous active-high reset.
module delay_pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Stage register: reset beats flush, flush beats advance; data never flushed.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its upstream neighbour's old value on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            // NOTE: data is cleared on reset as well so out reads 0 right after
            // reset; a flush leaves data alone because only valid is authoritative.
            r_data  <= '0;
        end else begin
            if (i_en) begin
                r_data <= i_data;
            end
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_en) begin
                r_valid <= i_valid;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/delay_pipe.sv
// delay_pipe: fixed-latency, stallable, flushable delay line of DEPTH stages.
// A value presented with go at an advancing edge leaves the last stage after
// DEPTH advancing edges; out_valid is meant to drive a Latch write_en.
// Optional feature macro: DELAY_PIPE_OCC_EN adds the registered occ port
// counting how many stages currently hold valid data.
module delay_pipe
    import delay_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             go,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
`ifdef DELAY_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occ
`endif
);

    // Reject degenerate configurations at elaboration.
    if (DEPTH < 1) begin : g_bad_depth
        $error("delay_pipe: DEPTH must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("delay_pipe: WIDTH must be >= 1");
    end

    // Index 0 is the pipe input; index i is the output of stage i.
    logic [WIDTH-1:0] w_data [0:DEPTH];
    logic [DEPTH:0]   w_valid;

    assign w_data[0]  = in;
    assign w_valid[0] = go;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        delay_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .i_en    (en),
            .i_flush (flush),
            .i_valid (w_valid[i]),
            .i_data  (w_data[i]),
            .o_valid (w_valid[i+1]),
            .o_data  (w_data[i+1])
        );
    end

    assign out       = w_data[DEPTH];
    assign out_valid = w_valid[DEPTH];

`ifdef DELAY_PIPE_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0] r_occ;

    // Occupancy counter: one in with go, one out when the last stage shifts away.
    // When full, the last stage is valid, so the count can never exceed DEPTH.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_occ <= '0;
        end else if (en) begin
            r_occ <= r_occ + OCC_W'(go) - OCC_W'(w_valid[DEPTH]);
        end
    end

    assign occ = r_occ;

    occ_matches_valid : assert property (
        @(posedge clk) disable iff (reset)
        r_occ == OCC_W'($countones(w_valid[DEPTH:1]))
    );
`endif

endmodule

// File: tb/tb_delay_pipe.sv
// Self-checking bench for delay_pipe (WIDTH=8, DEPTH=4, plus a DEPTH=1 instance).
// Table-driven directed vectors with hand-derived expectations, an independent
// scoreboard checking every cycle, a random phase, and a DEPTH=1 sequence.
// Checks occ only when DELAY_PIPE_OCC_EN is defined.
module tb_delay_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (DEPTH=4).
    logic             reset = 1'b1;
    logic             en    = 1'b0;
    logic             flush = 1'b0;
    logic             go    = 1'b0;
    logic [WIDTH-1:0] din   = '0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
`ifdef DELAY_PIPE_OCC_EN
    logic [2:0]       occ;
`endif

    delay_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .go        (go),
        .in        (din),
        .out       (dout),
        .out_valid (dout_valid)
`ifdef DELAY_PIPE_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    // DEPTH=1 DUT.
    logic             d1_reset = 1'b1;
    logic             d1_en    = 1'b0;
    logic             d1_flush = 1'b0;
    logic             d1_go    = 1'b0;
    logic [WIDTH-1:0] d1_in    = '0;
    logic [WIDTH-1:0] d1_out;
    logic             d1_valid;
`ifdef DELAY_PIPE_OCC_EN
    logic [0:0]       d1_occ;
`endif

    delay_pipe #(.WIDTH(WIDTH), .DEPTH(1)) u_dut1 (
        .clk       (clk),
        .reset     (d1_reset),
        .en        (d1_en),
        .flush     (d1_flush),
        .go        (d1_go),
        .in        (d1_in),
        .out       (d1_out),
        .out_valid (d1_valid)
`ifdef DELAY_PIPE_OCC_EN
        ,
        .occ       (d1_occ)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard: each accepted item remembers the advance count at which it
    // entered stage 1; it sits at the output once DEPTH-1 further advances happen.
    typedef struct {
        logic [WIDTH-1:0] data;
        int               entry;
    } sb_t;

    sb_t sb_q[$];
    int  adv = 0;

    task automatic sb_update(input logic r, input logic e, input logic f,
                             input logic g, input logic [WIDTH-1:0] d);
        if (r) begin
            sb_q.delete();
        end else begin
            if (e) begin
                adv++;
                while (sb_q.size() > 0 && (adv - sb_q[0].entry) >= DEPTH)
                    void'(sb_q.pop_front());
            end
            if (f) begin
                sb_q.delete();
            end else if (e && g) begin
                sb_q.push_back('{data: d, entry: adv});
            end
        end
    endtask

    task automatic sb_check();
        logic exp_v;
        exp_v = (sb_q.size() > 0) && ((adv - sb_q[0].entry + 1) == DEPTH);
        check("sb out_valid", 32'(dout_valid), 32'(exp_v));
        if (exp_v) begin
            check("sb out", 32'(dout), 32'(sb_q[0].data));
        end
`ifdef DELAY_PIPE_OCC_EN
        check("sb occ", 32'(occ), 32'(sb_q.size()));
`endif
    endtask

    // Apply one cycle to the main DUT, update the scoreboard, then sample #1 later.
    task automatic step(input logic r, input logic e, input logic f,
                        input logic g, input logic [WIDTH-1:0] d);
        reset = r; en = e; flush = f; go = g; din = d;
        @(posedge clk);
        sb_update(r, e, f, g, d);
        #1;
        cyc++;
        sb_check();
    endtask

    // Directed vectors: inputs at an edge and the outputs expected after it.
    typedef struct {
        logic             rst, en, flush, go;
        logic [WIDTH-1:0] din;
        logic             exp_valid;
        logic             chk_out;
        logic [WIDTH-1:0] exp_out;
        logic [2:0]       exp_occ;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic r, input logic e, input logic f, input logic g,
                     input logic [WIDTH-1:0] d, input logic ev, input logic co,
                     input logic [WIDTH-1:0] eo, input logic [2:0] eocc);
        vecs.push_back('{rst: r, en: e, flush: f, go: g, din: d,
                         exp_valid: ev, chk_out: co, exp_out: eo, exp_occ: eocc});
    endtask

    task automatic step1(input logic r, input logic e, input logic f,
                         input logic g, input logic [WIDTH-1:0] d,
                         input logic ev, input logic [WIDTH-1:0] eo, input logic eocc);
        d1_reset = r; d1_en = e; d1_flush = f; d1_go = g; d1_in = d;
        @(posedge clk);
        #1;
        cyc++;
        check("d1 out_valid", 32'(d1_valid), 32'(ev));
        if (ev || r) check("d1 out", 32'(d1_out), 32'(eo));
`ifdef DELAY_PIPE_OCC_EN
        check("d1 occ", 32'(d1_occ), 32'(eocc));
`else
        if (eocc === 1'bx) check("d1 occ unused", 32'(eocc), 32'd0);
`endif
    endtask

    initial begin
        // Reset held two cycles with aggressive inputs.
        v(1,1,0,1,8'hFF, 0,1,8'h00,0);
        v(1,1,0,1,8'hFF, 0,1,8'h00,0);
        // Single item latency.
        v(0,1,0,1,8'hA5, 0,0,8'h00,1);
        v(0,1,0,0,8'h00, 0,0,8'h00,1);
        v(0,1,0,0,8'h00, 0,0,8'h00,1);
        v(0,1,0,0,8'h00, 1,1,8'hA5,1);
        v(0,1,0,0,8'h00, 0,0,8'h00,0);
        v(0,1,0,0,8'h00, 0,0,8'h00,0);
        // Stream with a 3-cycle stall mid-stream.
        v(0,1,0,1,8'h01, 0,0,8'h00,1);
        v(0,1,0,1,8'h02, 0,0,8'h00,2);
        v(0,0,0,1,8'h99, 0,0,8'h00,2);
        v(0,0,0,1,8'h99, 0,0,8'h00,2);
        v(0,0,0,1,8'h99, 0,0,8'h00,2);
        v(0,1,0,1,8'h03, 0,0,8'h00,3);
        v(0,1,0,1,8'h04, 1,1,8'h01,4);
        v(0,1,0,0,8'h00, 1,1,8'h02,3);
        v(0,1,0,0,8'h00, 1,1,8'h03,2);
        v(0,1,0,0,8'h00, 1,1,8'h04,1);
        v(0,1,0,0,8'h00, 0,0,8'h00,0);
        // Flush with three in flight; the go presented with flush is dropped.
        v(0,1,0,1,8'h11, 0,0,8'h00,1);
        v(0,1,0,1,8'h22, 0,0,8'h00,2);
        v(0,1,0,1,8'h33, 0,0,8'h00,3);
        v(0,1,1,1,8'h77, 0,0,8'h00,0);
        for (int i = 0; i < 4; i++) v(0,1,0,0,8'h00, 0,0,8'h00,0);
        // Reset with all four stages valid.
        v(0,1,0,1,8'h41, 0,0,8'h00,1);
        v(0,1,0,1,8'h42, 0,0,8'h00,2);
        v(0,1,0,1,8'h43, 0,0,8'h00,3);
        v(0,1,0,1,8'h44, 1,1,8'h41,4);
        v(1,1,0,1,8'h55, 0,1,8'h00,0);
        for (int i = 0; i < 4; i++) v(0,1,0,0,8'h00, 0,0,8'h00,0);
        // Flush while stalled.
        v(0,1,0,1,8'h66, 0,0,8'h00,1);
        v(0,0,1,0,8'h00, 0,0,8'h00,0);
        for (int i = 0; i < 4; i++) v(0,1,0,0,8'h00, 0,0,8'h00,0);

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].en, vecs[k].flush, vecs[k].go, vecs[k].din);
            check("vec out_valid", 32'(dout_valid), 32'(vecs[k].exp_valid));
            if (vecs[k].chk_out) check("vec out", 32'(dout), 32'(vecs[k].exp_out));
`ifdef DELAY_PIPE_OCC_EN
            check("vec occ", 32'(occ), 32'(vecs[k].exp_occ));
`endif
        end

        // Random traffic, scoreboard only.
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 99) == 0),
                 logic'($urandom_range(0, 9) < 8),
                 logic'($urandom_range(0, 19) == 0),
                 logic'($urandom_range(0, 1)),
                 WIDTH'($urandom));
        end

        // DEPTH=1 instance.
        step1(1,0,0,0,8'h00, 0,8'h00,0);
        step1(0,1,0,1,8'h3C, 1,8'h3C,1);
        step1(0,1,0,0,8'h00, 0,8'h00,0);
        step1(0,1,0,1,8'h5A, 1,8'h5A,1);
        step1(0,0,0,1,8'h11, 1,8'h5A,1);
        step1(0,1,1,1,8'h22, 0,8'h00,0);
        step1(0,1,0,0,8'h00, 0,8'h00,0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
